sram_access_ctrl: RTL and testbench

// Per-access sequencer for the SRAM array, bitline column path and differential sense amplifiers.
// - Accepts one read or write request at a time over a valid/ready handshake.
// - Drives the precharge, wordline, sense-enable and write-driver controls in a fixed, non-overlapping order.
// - Captures the sense-amp outputs (preout) and returns them to the requester with a one-cycle response pulse.

---
 rtl/sram_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// Per-access SRAM sequencer: precharge -> wordline -> sense or write-drive -> one-cycle response.
// Read latency PRE+WL+SAE+1, write latency PRE+WR+1; req_ready is high only while idle.
module sram_access_ctrl #(
  parameter  int COLS    = 16,
  parameter  int ROWS    = 16,
  parameter  int PRE_CYC = 2,
  parameter  int WL_CYC  = 2,
  parameter  int SAE_CYC = 1,
  parameter  int WR_CYC  = 2,
  localparam int ADDR_W  = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [COLS-1:0]   rsp_rdata,
  output logic              pre_en,
  output logic [ROWS-1:0]   wl,
  output logic              sae,
  output logic              wdrv_en,
  output logic [COLS-1:0]   wdata_col,
  input  logic [COLS-1:0]   preout
);

  localparam int MAX_AB  = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int MAX_CD  = (SAE_CYC > WR_CYC) ? SAE_CYC : WR_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LD  = CNT_W'(WL_CYC - 1);
  localparam logic [CNT_W-1:0] SAE_LD = CNT_W'(SAE_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(WR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WL,
    S_SENSE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic              w_accept;
  logic              w_last;
  logic              w_oob;
  logic              w_wl_on;
  logic [ROWS-1:0]   w_wl_dec;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == '0);
  assign w_oob    = (32'(req_addr) >= 32'(ROWS));

  // Phase counter holds remaining cycles minus one; every state change reloads it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - CNT_W'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = PRE_LD;
        if (w_accept) w_state_nxt = S_PRE;
      end
      S_PRE: begin
        if (w_last) begin
          w_state_nxt = r_we ? S_WRITE : S_WL;
          w_cnt_nxt   = r_we ? WR_LD : WL_LD;
        end
      end
      S_WL: begin
        if (w_last) begin
          w_state_nxt = S_SENSE;
          w_cnt_nxt   = SAE_LD;
        end
      end
      S_SENSE, S_WRITE: begin
        if (w_last) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = '0;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = PRE_LD;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = PRE_LD;
      end
    endcase
  end

  // Out-of-range rows decode to no wordline at all.
  always_comb begin
    w_wl_dec = '0;
    for (int i = 0; i < ROWS; i++) begin
      w_wl_dec[i] = !r_err && (r_addr == ADDR_W'(i));
    end
  end

  assign w_wl_on = (w_state_nxt == S_WL) || (w_state_nxt == S_SENSE) || (w_state_nxt == S_WRITE);

  // Controls are registered from the next state so each is high exactly while its state is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= PRE_LD;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      req_ready <= 1'b1;
      pre_en    <= 1'b0;
      wl        <= '0;
      sae       <= 1'b0;
      wdrv_en   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wdata_col <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_accept) begin
        r_we      <= req_we;
        r_addr    <= req_addr;
        r_err     <= w_oob;
        wdata_col <= req_wdata;
      end
      req_ready <= (w_state_nxt == S_IDLE);
      pre_en    <= (w_state_nxt == S_PRE);
      sae       <= (w_state_nxt == S_SENSE);
      wdrv_en   <= (w_state_nxt == S_WRITE);
      wl        <= w_wl_on ? w_wl_dec : '0;
      rsp_valid <= (w_state_nxt == S_RESP);
      rsp_err   <= (w_state_nxt == S_RESP) && r_err;
      if ((r_state == S_SENSE) && w_last) rsp_rdata <= preout;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed and randomised checks of sram_access_ctrl across three timing/row configurations.
module tb_sram_access_ctrl;

  localparam int NCFG = 3;
  localparam int RW [NCFG] = '{16, 12, 16};
  localparam int PC [NCFG] = '{2, 1, 4};
  localparam int WC [NCFG] = '{2, 3, 1};
  localparam int SC [NCFG] = '{1, 2, 4};
  localparam int RC [NCFG] = '{2, 4, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic [15:0] preout;

  logic        vld   [NCFG];
  logic        rdy   [NCFG];
  logic        rspv  [NCFG];
  logic        rerr  [NCFG];
  logic        pre   [NCFG];
  logic        sae   [NCFG];
  logic        wdrv  [NCFG];
  logic [15:0] rdata [NCFG];
  logic [15:0] wdcol [NCFG];
  logic [15:0] wl_o  [NCFG];

  logic        oob      [NCFG];
  logic [15:0] exp_rd   [NCFG];
  logic        rd_known [NCFG];
  logic        mon_en;
  int          inv_err;
  int          n_checks;
  int          n_fail;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : gen_dut
    logic [RW[g]-1:0] wl_loc;
    assign wl_o[g] = 16'(wl_loc);
    sram_access_ctrl #(
      .COLS(16), .ROWS(RW[g]), .PRE_CYC(PC[g]), .WL_CYC(WC[g]), .SAE_CYC(SC[g]), .WR_CYC(RC[g])
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(vld[g]), .req_ready(rdy[g]), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rspv[g]), .rsp_err(rerr[g]), .rsp_rdata(rdata[g]),
      .pre_en(pre[g]), .wl(wl_loc), .sae(sae[g]), .wdrv_en(wdrv[g]),
      .wdata_col(wdcol[g]), .preout(preout)
    );
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < NCFG; g++) begin
      if (vld[g] && rdy[g]) oob[g] = (32'(req_addr) >= RW[g]);
    end
  end

  // Array-control invariants; sense without wordline is legal only for out-of-range rows.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < NCFG; g++) begin
        if (pre[g] && (wl_o[g] != 16'h0)) inv_err++;
        if (sae[g] && (wl_o[g] == 16'h0) && !oob[g]) inv_err++;
        if (wdrv[g] && sae[g]) inv_err++;
        if (!$onehot0(wl_o[g])) inv_err++;
      end
    end
  end

  task automatic run_txn(input int g, input logic we, input logic [3:0] addr,
                         input logic [15:0] wd, input logic [15:0] po);
    int          p, w, s, r, lat, exp_lat, wbad, n;
    logic        oob_e, err_o;
    logic [15:0] wl_e;
    logic [63:0] pm, wm, sm, dm, rm, exp_wm, exp_sm, exp_dm;
    p = PC[g]; w = WC[g]; s = SC[g]; r = RC[g];
    oob_e  = (32'(addr) >= RW[g]);
    wl_e   = oob_e ? 16'h0 : (16'h1 << addr);
    exp_wm = oob_e ? 64'h0 : (we ? span(p + 1, p + r) : span(p + 1, p + w + s));
    exp_sm = we ? 64'h0 : span(p + w + 1, p + w + s);
    exp_dm = we ? span(p + 1, p + r) : 64'h0;
    exp_lat = we ? (p + r + 1) : (p + w + s + 1);

    @(negedge clk);
    n = 0;
    while (!rdy[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("ready_idle", 64'(rdy[g]), 64'h1);
    req_we = we; req_addr = addr; req_wdata = wd; preout = po; vld[g] = 1'b1;
    @(negedge clk);
    vld[g] = 1'b0;
    check_val("wdata_col", 64'(wdcol[g]), 64'(wd));

    pm = '0; wm = '0; sm = '0; dm = '0; rm = '0; lat = 0; wbad = 0; err_o = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (pre[g])  pm[k] = 1'b1;
      if (sae[g])  sm[k] = 1'b1;
      if (wdrv[g]) dm[k] = 1'b1;
      if (rdy[g])  rm[k] = 1'b1;
      if (wl_o[g] != 16'h0) begin
        wm[k] = 1'b1;
        if (wl_o[g] != wl_e) wbad++;
      end
      if (rspv[g]) begin
        lat   = k;
        err_o = rerr[g];
        break;
      end
    end
    check_val("latency",  64'(lat), 64'(exp_lat));
    check_val("pre_en",   pm, span(1, p));
    check_val("wl_cycles", wm, exp_wm);
    check_val("wl_value", 64'(wbad), 64'h0);
    check_val("sae",      sm, exp_sm);
    check_val("wdrv_en",  dm, exp_dm);
    check_val("busy_rdy", rm, 64'h0);
    check_val("rsp_err",  64'(err_o), 64'(oob_e));
    if (!we && !oob_e) begin
      exp_rd[g] = po;
      rd_known[g] = 1'b1;
    end else if (!we) begin
      rd_known[g] = 1'b0;
    end
    if (rd_known[g]) check_val("rsp_rdata", 64'(rdata[g]), 64'(exp_rd[g]));

    @(negedge clk);
    check_val("rsp_pulse", 64'(rspv[g]), 64'h0);
    check_val("ready_back", 64'(rdy[g]), 64'h1);
  endtask

  task automatic back_to_back();
    int   r1, g1, g2, r2;
    logic rdy_seen;
    r1 = -1; g1 = -1; g2 = -1; r2 = -1; rdy_seen = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 4'd5; req_wdata = 16'h0; preout = 16'h0F0F; vld[0] = 1'b1;
    @(negedge clk);
    req_we = 1'b1; req_addr = 4'd9; req_wdata = 16'hBEEF;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (r1 < 0) begin
        if (rdy[0]) rdy_seen = 1'b1;
        if (rspv[0]) r1 = k;
      end else begin
        if (g1 < 0 && rdy[0]) g1 = k;
        if (g2 < 0 && pre[0]) begin
          g2 = k;
          vld[0] = 1'b0;
        end
        if (r2 < 0 && rspv[0]) r2 = k;
      end
      if (r2 >= 0) break;
    end
    vld[0] = 1'b0;
    check_val("b2b_rd_lat",   64'(r1), 64'd6);
    check_val("b2b_rdy_busy", 64'(rdy_seen), 64'h0);
    check_val("b2b_rdy_gap",  64'(g1 - r1), 64'd1);
    check_val("b2b_pre_gap",  64'(g2 - r1), 64'd2);
    check_val("b2b_wr_rsp",   64'(r2 - r1), 64'd6);
    check_val("b2b_rdata",    64'(rdata[0]), 64'h0F0F);
    check_val("b2b_wdcol",    64'(wdcol[0]), 64'hBEEF);
    exp_rd[0] = 16'h0F0F;
    rd_known[0] = 1'b1;
  endtask

  task automatic reset_in_sense();
    logic seen;
    @(negedge clk);
    req_we = 1'b0; req_addr = 4'd7; preout = 16'hFFFF; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst_in_sense", 64'(sae[0]), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_pre",   64'(pre[0]),  64'h0);
    check_val("rst_wl",    64'(wl_o[0]), 64'h0);
    check_val("rst_sae",   64'(sae[0]),  64'h0);
    check_val("rst_wdrv",  64'(wdrv[0]), 64'h0);
    check_val("rst_rspv",  64'(rspv[0]), 64'h0);
    check_val("rst_rdy",   64'(rdy[0]),  64'h1);
    check_val("rst_rdata", 64'(rdata[0]), 64'h0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rspv[0]) seen = 1'b1;
    end
    check_val("rst_no_rsp", 64'(seen), 64'h0);
    for (int g = 0; g < NCFG; g++) begin
      exp_rd[g] = 16'h0;
      rd_known[g] = 1'b1;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; inv_err = 0; mon_en = 1'b0;
    rst = 1'b1; req_we = 1'b0; req_addr = 4'd0; req_wdata = 16'h0; preout = 16'h0;
    for (int g = 0; g < NCFG; g++) begin
      vld[g] = 1'b0; oob[g] = 1'b0; exp_rd[g] = 16'h0; rd_known[g] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("reset_rdy",   64'(rdy[0]),   64'h1);
    check_val("reset_pre",   64'(pre[0]),   64'h0);
    check_val("reset_wl",    64'(wl_o[0]),  64'h0);
    check_val("reset_sae",   64'(sae[0]),   64'h0);
    check_val("reset_wdrv",  64'(wdrv[0]),  64'h0);
    check_val("reset_rspv",  64'(rspv[0]),  64'h0);
    check_val("reset_rerr",  64'(rerr[0]),  64'h0);
    check_val("reset_rdata", 64'(rdata[0]), 64'h0);
    check_val("reset_wdcol", 64'(wdcol[0]), 64'h0);
    mon_en = 1'b1;

    run_txn(0, 1'b0, 4'd3,  16'h0000, 16'hA5C3);
    run_txn(0, 1'b1, 4'd15, 16'h1234, 16'h7777);
    back_to_back();
    reset_in_sense();
    run_txn(1, 1'b0, 4'd13, 16'h5555, 16'h3C3C);
    run_txn(1, 1'b0, 4'd11, 16'h0000, 16'hC001);
    run_txn(1, 1'b1, 4'd12, 16'h9999, 16'h0000);
    run_txn(2, 1'b0, 4'd0,  16'h0000, 16'h8001);
    run_txn(2, 1'b1, 4'd1,  16'hABCD, 16'h1111);
    for (int i = 0; i < 24; i++) begin
      run_txn(i % NCFG, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              16'($urandom), 16'($urandom));
    end

    check_val("invariants", 64'(inv_err), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
